player_key_conditioner: RTL and testbench
=========================================

Name: player_key_conditioner

Overview:
- Upstream input stage of the tug-of-war playfield. Converts two raw, asynchronous, active-low, bouncy pushbuttons (left and right player) into clean single-cycle press pulses.
- Those pulses are the L/R move inputs of every playfield light cell.
- One press yields exactly one pulse, regardless of hold time or contact bounce.
- A freeze input blocks all moves once a winner is declared.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a press or release (5 ms at 50 MHz). Must be >= 1; benches override to 4.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Derived, not overridden.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- key_l_n  input  1  raw left button, active-low, asynchronous
- key_r_n  input  1  raw right button, active-low, asynchronous
- freeze  input  1  high = game over; suppresses pulses
- pulse_l  output  1  one-cycle left move pulse
- pulse_r  output  1  one-cycle right move pulse
- held_l  output  1  left button debounced-pressed
- held_r  output  1  right button debounced-pressed

Behaviour:
- Interface: clock clk; reset is reset, synchronous, active-high.
- Channels: two identical, fully independent channels (L, R). Each has a 2-flop synchronizer (s1, s2), a CNT_W counter and a 4-state FSM.
- Reset: synchronizer flops = 1 (released); FSM = IDLE; counter = 0; pulse_x = 0; held_x = 0. Reset mid-debounce or mid-hold discards all progress.
- Polarity: "pressed" means s2 == 0.
- IDLE:
  - pressed -> PRESS_WAIT, cnt = 0.
  - released -> stay.
- PRESS_WAIT:
  - released -> IDLE (glitch rejected, no pulse).
  - pressed and cnt == DEBOUNCE_CYCLES-1 -> HELD, pulse_x registered to 1.
  - pressed otherwise -> cnt + 1.
- HELD:
  - pressed -> stay; no further pulses, no auto-repeat.
  - released -> RELEASE_WAIT, cnt = 0.
- RELEASE_WAIT:
  - pressed -> HELD, no pulse (bounce on release).
  - released and cnt == DEBOUNCE_CYCLES-1 -> IDLE.
  - released otherwise -> cnt + 1.
- Outputs:
  - held_x = 1 in HELD and RELEASE_WAIT; registered, so it asserts in the same cycle as pulse_x.
  - pulse_x is registered, high exactly one cycle: the first cycle in HELD.
- Latency: raw key first sampled low at edge 0 and held -> pulse_x high in the cycle after edge DEBOUNCE_CYCLES+2. With DEBOUNCE_CYCLES = 4, that is the cycle after edge 6.
- Release-to-repress: a new pulse requires a full debounced release (reaching IDLE) followed by a full debounced press.
- Freeze:
  - pulse_x = registered pulse AND NOT freeze, sampled in the same cycle as the pulse.
  - The FSM keeps running during freeze. A press accepted during freeze is consumed: it does not fire when freeze drops.
  - held_x is not gated.
- Simultaneous presses: channels never interact. pulse_l and pulse_r may both be high in the same cycle. Both are forwarded unchanged; the playfield treats L&R as no move.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- No combinational path from any input to any output.

Test Plan:
- Clean press (DEBOUNCE_CYCLES=4): reset 2 cycles; key_l_n = 0 from edge 0, held 20 cycles -> pulse_l = 1 only in the cycle after edge 6; held_l = 1 from that cycle on; pulse_r = 0 throughout.
- Bounce rejection: key_r_n low 3 cycles, high 1, low 3, high -> pulse_r never asserts; held_r stays 0.
- Long hold and release bounce: key_l_n low 30 cycles -> exactly one pulse_l.
  - Release with a 2-cycle re-press glitch -> no pulse; held_l drops 4 cycles after the final stable release is synchronized.
  - Second clean press -> exactly one more pulse_l.
- Simultaneous: both keys low on the same edge -> pulse_l and pulse_r both high in the same single cycle.
- Freeze: freeze = 1, key_l_n pressed and held -> pulse_l stays 0; held_l = 1. Deassert freeze while still held -> still no pulse. Release, then re-press with freeze = 0 -> one pulse.
- Reset mid-operation: assert reset while in PRESS_WAIT (3 cycles into debounce) -> all outputs 0 next cycle. With the key still held after reset drops -> pulse after a full DEBOUNCE_CYCLES+2 edges counted from the first post-reset edge.

Source files
------------

// File: rtl/player_key_conditioner.sv
// rtl/player_key_conditioner.sv - two-channel pushbutton synchronizer, debouncer and press-pulse generator

// One button channel: synchronize, debounce, emit one pulse per accepted press.
module player_key_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic freeze,
  output logic pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             s1;
  logic             s2;
  logic             pressed;
  logic             accept;

  assign pressed = ~s2;

  // Two-flop synchronizer; resets to the released level so no false press follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  // State, counter and registered outputs; freeze is folded into the pulse register
  // so no input reaches an output combinationally and a frozen press is simply lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      held  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pulse <= accept & ~freeze;
      held  <= (state_nx == HELD) || (state_nx == RELEASE_WAIT);
    end
  end

  // Debounce decisions: a level must persist DEBOUNCE_CYCLES+1 samples to be accepted.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (pressed) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx = HELD;
          accept   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_nx = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// Left and right channels are identical and never interact.
module player_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic freeze,
  output logic pulse_l,
  output logic pulse_r,
  output logic held_l,
  output logic held_r
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  player_key_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_left (
    .clk   (clk),
    .reset (reset),
    .key_n (key_l_n),
    .freeze(freeze),
    .pulse (pulse_l),
    .held  (held_l)
  );

  player_key_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_right (
    .clk   (clk),
    .reset (reset),
    .key_n (key_r_n),
    .freeze(freeze),
    .pulse (pulse_r),
    .held  (held_r)
  );

endmodule

// File: tb/tb_player_key_conditioner.sv
// tb/tb_player_key_conditioner.sv - scoreboard bench for player_key_conditioner
module tb_player_key_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_l_n = 1'b1;
  logic key_r_n = 1'b1;
  logic freeze = 1'b0;
  logic pulse_l, pulse_r, held_l, held_r;

  player_key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .reset  (reset),
    .key_l_n(key_l_n),
    .key_r_n(key_r_n),
    .freeze (freeze),
    .pulse_l(pulse_l),
    .pulse_r(pulse_r),
    .held_l (held_l),
    .held_r (held_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_on = 0;
  bit done = 0;

  // reference model: raw delay line, sample history, debounced level
  bit r1[2];
  bit r2[2];
  bit db[2];
  bit hist[2][D+1];
  int nvalid[2];
  int exp_ql[$];
  int exp_qr[$];

  // directed checks requested by stimulus, evaluated by the monitor
  int dq_sel[$];
  int dq_exp[$];
  int obs_cnt[2];
  int obs_last[2];

  task automatic model_update();
    bit raw[2];
    bit smp;
    bit all;
    raw[0] = key_l_n;
    raw[1] = key_r_n;
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        r1[c] = 1'b1;
        r2[c] = 1'b1;
        db[c] = 1'b0;
        nvalid[c] = 0;
      end else begin
        smp = r2[c];
        r2[c] = r1[c];
        r1[c] = raw[c];
        for (int k = D; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = smp;
        if (nvalid[c] < D + 1) nvalid[c]++;
        // db=0 (released) flips on D+1 low samples; db=1 flips on D+1 high samples
        if (nvalid[c] == D + 1) begin
          all = 1'b1;
          for (int k = 0; k <= D; k++) if (hist[c][k] != db[c]) all = 1'b0;
          if (all) begin
            db[c] = ~db[c];
            if (db[c] && !freeze) begin
              if (c == 0) exp_ql.push_back(cyc);
              else exp_qr.push_back(cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(input int sel, input int e);
    dq_sel.push_back(sel);
    dq_exp.push_back(e);
  endtask

  task automatic check_ch(input int c, input logic p, input logic h);
    int e;
    string nm;
    nm = (c == 0) ? "l" : "r";
    checks++;
    if (h !== db[c]) begin
      errors++;
      $display("FAIL held_%s edge %0d: got %b expected %b", nm, cyc - 1, h, db[c]);
    end
    checks++;
    if (p === 1'b1) begin
      obs_cnt[c]++;
      obs_last[c] = cyc - 1;
      if ((c == 0 ? exp_ql.size() : exp_qr.size()) == 0) begin
        errors++;
        $display("FAIL pulse_%s edge %0d: got 1 expected 0 (no press pending)", nm, cyc - 1);
      end else begin
        e = (c == 0) ? exp_ql.pop_front() : exp_qr.pop_front();
        if (e != cyc - 1) begin
          errors++;
          $display("FAIL pulse_%s timing: got edge %0d expected edge %0d", nm, cyc - 1, e);
        end
      end
    end else if (p !== 1'b0) begin
      errors++;
      $display("FAIL pulse_%s edge %0d: got %b expected 0/1", nm, cyc - 1, p);
    end else if (c == 0 && exp_ql.size() > 0 && exp_ql[0] <= cyc - 1) begin
      e = exp_ql.pop_front();
      errors++;
      $display("FAIL pulse_l missing: got 0 expected 1 at edge %0d", e);
    end else if (c == 1 && exp_qr.size() > 0 && exp_qr[0] <= cyc - 1) begin
      e = exp_qr.pop_front();
      errors++;
      $display("FAIL pulse_r missing: got 0 expected 1 at edge %0d", e);
    end
  endtask

  // monitor: compares DUT outputs with the scoreboard between clock edges
  always @(negedge clk) begin
    int sel, e, got;
    if (mon_on) begin
      check_ch(0, pulse_l, held_l);
      check_ch(1, pulse_r, held_r);
      while (dq_sel.size() > 0) begin
        sel = dq_sel.pop_front();
        e = dq_exp.pop_front();
        got = (sel < 2) ? obs_cnt[sel] : obs_last[sel - 2];
        checks++;
        if (got != e) begin
          errors++;
          $display("FAIL directed_%0d: got %0d expected %0d", sel, got, e);
        end
      end
      if (done) begin
        checks++;
        if (exp_ql.size() != 0 || exp_qr.size() != 0) begin
          errors++;
          $display("FAIL leftover_pulses: got %0d/%0d pending expected 0/0", exp_ql.size(), exp_qr.size());
        end
      end
    end
  end

  int p0;
  int rem[2];
  initial begin
    obs_cnt[0] = 0; obs_cnt[1] = 0;
    obs_last[0] = -1; obs_last[1] = -1;
    @(negedge clk);
    mon_on = 1;
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    ticks(2);

    // clean press on left
    p0 = cyc;
    key_l_n = 1'b0;
    ticks(20);
    key_l_n = 1'b1;
    ticks(10);
    req(0, 1); req(1, 0); req(2, p0 + D + 2);

    // bounce on right never accepted
    key_r_n = 1'b0; ticks(3);
    key_r_n = 1'b1; ticks(1);
    key_r_n = 1'b0; ticks(3);
    key_r_n = 1'b1; ticks(10);
    req(1, 0);

    // long hold, release with re-press glitch, second press
    key_l_n = 1'b0; ticks(30);
    key_l_n = 1'b1; ticks(3);
    key_l_n = 1'b0; ticks(2);
    key_l_n = 1'b1; ticks(12);
    req(0, 2);
    key_l_n = 1'b0; ticks(10);
    key_l_n = 1'b1; ticks(10);
    req(0, 3);

    // simultaneous presses
    p0 = cyc;
    key_l_n = 1'b0; key_r_n = 1'b0; ticks(10);
    key_l_n = 1'b1; key_r_n = 1'b1; ticks(10);
    req(2, p0 + D + 2); req(3, p0 + D + 2); req(0, 4); req(1, 1);

    // frozen press is consumed
    freeze = 1'b1;
    key_l_n = 1'b0; ticks(10);
    freeze = 1'b0; ticks(5);
    req(0, 4);
    key_l_n = 1'b1; ticks(10);
    key_l_n = 1'b0; ticks(10);
    key_l_n = 1'b1; ticks(10);
    req(0, 5);

    // reset in the middle of debounce, key kept low
    key_l_n = 1'b0; ticks(5);
    reset = 1'b1; ticks(1);
    reset = 1'b0;
    p0 = cyc;
    ticks(12);
    key_l_n = 1'b1; ticks(10);
    req(0, 6); req(2, p0 + D + 2);

    // randomized segments, occasional freeze toggles and resets
    rem[0] = 1; rem[1] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        rem[c]--;
        if (rem[c] == 0) begin
          if (c == 0) key_l_n = ~key_l_n; else key_r_n = ~key_r_n;
          rem[c] = $urandom_range(1, 3 * D);
        end
      end
      if ($urandom_range(0, 39) == 0) freeze = ~freeze;
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end

    reset = 1'b0; freeze = 1'b0; key_l_n = 1'b1; key_r_n = 1'b1;
    ticks(20);
    done = 1;
    tick();
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
